// File: rtl/pwm_breathe_array.sv
// Multi-channel breathing-LED PWM: prescaler, PWM period counter and a shared
// triangular duty ramp, with per-channel off / on / breathe / inverse-breathe.
module pwm_breathe_array #(
  parameter int CH     = 4,
  parameter int PRESC  = 500,
  parameter int PERIOD = 1000,
  parameter int STEP   = 1,
  parameter int CW     = $clog2(PERIOD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   pio_led,
  output logic            frame,
  output logic            cycle_done
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESC - 1);
  localparam logic [CW-1:0] PCNT_MAX = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] STEP_C   = CW'(STEP);
  localparam logic [CW:0]   PERIOD_X = (CW + 1)'(PERIOD);
  localparam logic [CW:0]   STEP_X   = (CW + 1)'(STEP);

  logic [PW-1:0] pre;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] duty;
  logic          dir;

  logic          tick;
  logic          wrap;
  logic [CW:0]   up_sum;
  logic [CW-1:0] inv_thr;
  logic [CW-1:0] duty_nxt;
  logic          dir_nxt;
  logic          done_nxt;
  logic          b;
  logic          ib;
  logic [CH-1:0] led_nxt;

  always_comb begin
    tick     = en && (pre == PRE_MAX);
    wrap     = tick && (pcnt == PCNT_MAX);
    up_sum   = {1'b0, duty} + STEP_X;
    inv_thr  = PERIOD_C - duty;
    duty_nxt = duty;
    dir_nxt  = dir;
    done_nxt = 1'b0;
    // Ramp moves only at the frame boundary, so a frame never sees two duties.
    if (wrap) begin
      if (!dir) begin
        if (up_sum >= PERIOD_X) begin
          duty_nxt = PERIOD_C;
          dir_nxt  = 1'b1;
        end else begin
          duty_nxt = up_sum[CW-1:0];
        end
      end else begin
        if ({1'b0, duty} <= STEP_X) begin
          duty_nxt = '0;
          dir_nxt  = 1'b0;
          done_nxt = (duty != '0);
        end else begin
          duty_nxt = duty - STEP_C;
        end
      end
    end
  end

  always_comb begin
    b       = (pcnt < duty);
    ib      = (pcnt < inv_thr);
    led_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   led_nxt[i] = 1'b0;
        2'b01:   led_nxt[i] = 1'b1;
        2'b10:   led_nxt[i] = b;
        default: led_nxt[i] = ib;
      endcase
    end
    if (!en) led_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      pcnt       <= '0;
      duty       <= '0;
      dir        <= 1'b0;
      pio_led    <= '0;
      frame      <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      if (tick)    pre <= '0;
      else if (en) pre <= pre + 1'b1;
      if (tick)    pcnt <= wrap ? '0 : pcnt + 1'b1;
      duty       <= duty_nxt;
      dir        <= dir_nxt;
      pio_led    <= led_nxt;
      frame      <= wrap;
      cycle_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_breathe_array.sv
// Directed bench for pwm_breathe_array with CH=4, PRESC=2, PERIOD=4, STEP=1.
module tb_pwm_breathe_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mode;
  logic [3:0] pio_led;
  logic       frame;
  logic       cycle_done;

  int n_checks = 0;
  int n_fail   = 0;

  int n, fidx, last_f, c0, c1, cd_cnt;
  int exp_duty [0:11];
  int exp_gap  [0:11];

  pwm_breathe_array #(.CH(4), .PRESC(2), .PERIOD(4), .STEP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .pio_led    (pio_led),
    .frame      (frame),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counts channel-high samples per frame and checks at each frame pulse.
  // Samples on the negedge; input changes follow the sample.
  task automatic run(input int ncyc, input bit with_events);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      n++;
      c0     += int'(pio_led[0]);
      c1     += int'(pio_led[1]);
      cd_cnt += int'(cycle_done);
      if (frame) begin
        if (fidx < 12) begin
          check("frame_spacing", n - last_f, exp_gap[fidx]);
          check("ch0_high", c0, 2 * exp_duty[fidx]);
          check("ch1_high", c1, 2 * (4 - exp_duty[fidx]));
          check("cycle_done_at_frame", int'(cycle_done), (with_events && fidx == 7) ? 1 : 0);
        end else begin
          check("extra_frame", fidx, 11);
        end
        fidx++;
        last_f = n;
        c0 = 0;
        c1 = 0;
      end
      if (with_events) begin
        if (n == 20) begin check("ch2_before_on", int'(pio_led[2]), 0); mode[5:4] = 2'b01; end
        if (n == 21) check("ch2_rise", int'(pio_led[2]), 1);
        if (n == 24) begin check("ch2_before_off", int'(pio_led[2]), 1); mode[5:4] = 2'b00; end
        if (n == 25) check("ch2_fall", int'(pio_led[2]), 0);
        if (n == 72) mode[7:6] = 2'b01;
        if (n == 84) en = 1'b0;
        if (n >= 85 && n <= 94) begin
          check("gap_pio", int'(pio_led), 0);
          check("gap_frame", int'(frame), 0);
        end
        if (n == 94) en = 1'b1;
      end
    end
  endtask

  initial begin
    exp_duty = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};
    exp_gap  = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 18, 8};

    // Reset with everything forced on: outputs stay low until release.
    rst  = 1'b1;
    en   = 1'b1;
    mode = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pio", int'(pio_led), 0);
      check("rst_frame", int'(frame), 0);
      check("rst_cycle_done", int'(cycle_done), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("pio_after_release", int'(pio_led), 15);

    // Ramp, complementary, static switch and enable gap in one run.
    rst  = 1'b1;
    mode = 8'h0E;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    n      = 0;
    fidx   = 0;
    last_f = 0;
    c0     = 0;
    c1     = 0;
    cd_cnt = 0;
    run(100, 1'b1);
    check("frames_run1", fidx, 11);
    check("cycle_done_count_run1", cd_cnt, 1);

    // Reset in the duty=3 upswing frame.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_frame", int'(frame), 0);
      check("midrst_cycle_done", int'(cycle_done), 0);
      check("midrst_pio", int'(pio_led), 0);
    end
    rst    = 1'b0;
    n      = 0;
    fidx   = 0;
    last_f = 0;
    c0     = 0;
    c1     = 0;
    cd_cnt = 0;
    run(24, 1'b0);
    check("frames_run2", fidx, 3);
    check("cycle_done_count_run2", cd_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
